// File: rtl/uart_tx.sv
// uart_tx: register-mapped UART transmitter with a TX FIFO; define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        we_i,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_TX_PARITY_EN
  localparam int CTRL_W = 3;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  localparam int CTRL_W = 2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif
  state_e state_q, state_d, after_data;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic ovf_q, ovf_d;
  logic [15:0] baud_q, baud_d, cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_q, bit_d;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic sel_ctrl, sel_stat, sel_baud, sel_tx;
  logic full, empty, busy, tx_en, irq_en, bit_end, push, pop;
  logic unused_bits;
  assign unused_bits = ^{addr_i[31:8], data_i[31:16]};
  assign sel_ctrl = addr_i[7:0] == 8'h00;
  assign sel_stat = addr_i[7:0] == 8'h04;
  assign sel_baud = addr_i[7:0] == 8'h08;
  assign sel_tx = addr_i[7:0] == 8'h0C;
  assign tx_en = ctrl_q[0];
  assign irq_en = ctrl_q[1];
  assign full = count_q == CW'(FIFO_DEPTH);
  assign empty = count_q == '0;
  assign busy = state_q != IDLE;
  assign bit_end = cnt_q == 16'd0;
  assign irq_o = irq_en & empty & ~busy;
  assign pop = tx_en & ~empty & (state_q == IDLE | (state_q == STOP & bit_end));
  assign push = we_i & sel_tx & (~full | pop);
  assign ctrl_d = we_i & sel_ctrl ? data_i[CTRL_W-1:0] : ctrl_q;
  assign baud_d = we_i & sel_baud ? (data_i[15:0] == 16'd0 ? 16'd1 : data_i[15:0]) : baud_q;
  assign ovf_d = (we_i & sel_tx & full & ~pop) | (ovf_q & ~(we_i & sel_stat & data_i[3]));
  assign data_o = sel_ctrl ? 32'(ctrl_q)
                : sel_stat ? {23'd0, 5'(count_q), ovf_q, empty, full, busy}
                : sel_baud ? {16'd0, baud_q}
                : 32'd0;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
  assign after_data = ctrl_q[2] ? PARITY : STOP;
`else
  assign after_data = STOP;
`endif
  always_comb begin
    tx_o = 1'b1;
    if (state_q == START) tx_o = 1'b0;
    else if (state_q == DATA) tx_o = shreg_q[0];
`ifdef UART_TX_PARITY_EN
    else if (state_q == PARITY) tx_o = par_q;
`endif
  end
  // Each state lasts BAUD clocks; BAUD is sampled only when a bit is entered.
  always_comb begin
    state_d = state_q;
    cnt_d = bit_end ? cnt_q : cnt_q - 16'd1;
    shreg_d = shreg_q;
    bit_d = bit_q;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
`endif
    if (pop) begin
      state_d = START;
      cnt_d = baud_q - 16'd1;
      shreg_d = mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
      par_d = ^mem_q[rptr_q];
`endif
    end else if (busy && bit_end) begin
      cnt_d = baud_q - 16'd1;
      case (state_q)
        START: begin
          state_d = DATA;
          bit_d = 3'd0;
        end
        DATA: begin
          shreg_d = shreg_q >> 1;
          bit_d = bit_q + 3'd1;
          state_d = bit_q == 3'd7 ? after_data : DATA;
        end
`ifdef UART_TX_PARITY_EN
        PARITY: state_d = STOP;
`endif
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i[7:0];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shreg_q <= '0;
      bit_q <= '0;
      ctrl_q <= '0;
      ovf_q <= 1'b0;
      baud_q <= 16'h01B2;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shreg_q <= shreg_d;
      bit_q <= bit_d;
      ctrl_q <= ctrl_d;
      ovf_q <= ovf_d;
      baud_q <= baud_d;
      wptr_q <= wptr_q + AW'(push);
      rptr_q <= rptr_q + AW'(pop);
      count_q <= count_q + CW'(push) - CW'(pop);
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized scoreboard bench; a line monitor decodes tx_o frames against queued bytes.
module tb_uart_tx;
  localparam int DEPTH = 8;
  localparam logic [7:0] A_CTRL = 8'h00;
  localparam logic [7:0] A_STAT = 8'h04;
  localparam logic [7:0] A_BAUD = 8'h08;
  localparam logic [7:0] A_TX = 8'h0C;
`ifdef UART_TX_PARITY_EN
  localparam logic [31:0] CTRL_MASK = 32'h7;
`else
  localparam logic [31:0] CTRL_MASK = 32'h3;
`endif
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic we_i = 1'b0;
  logic [31:0] data_o;
  logic tx_o, irq_o;
  int checks = 0;
  int fails = 0;
  logic [7:0] sb[$];
  int mon_baud = 1;
  logic mon_par = 1'b0;
  logic mon_busy = 1'b0;
  uart_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .we_i(we_i), .tx_o(tx_o), .irq_o(irq_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk_i);
    addr_i = {24'd0, a};
    data_i = d;
    we_i = 1'b1;
    @(negedge clk_i);
    we_i = 1'b0;
    data_i = '0;
  endtask
  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk_i);
    addr_i = {24'd0, a};
    #1;
    chk(nm, data_o, exp);
  endtask
  task automatic push_byte(input logic [31:0] d);
    wr(A_TX, d);
    sb.push_back(d[7:0]);
  endtask
  task automatic wait_start(input string nm);
    int n;
    n = 0;
    while (tx_o !== 1'b0 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk(nm, (n < 20) ? 32'd1 : 32'd0, 32'd1);
  endtask
  task automatic drain(input string nm, input int lim);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < lim) begin
      @(negedge clk_i);
      n++;
    end
    chk(nm, (n < lim) ? 32'd1 : 32'd0, 32'd1);
    repeat (2) @(negedge clk_i);
  endtask
  logic [10:0] m_bits;
  logic [7:0] m_e;
  int m_b, m_nb, m_bad, m_badc;
  logic m_abort, m_got, m_exp;
  always begin
    @(negedge clk_i);
    if (!rst_i && tx_o === 1'b0) begin
      mon_busy = 1'b1;
      m_b = mon_baud;
      m_nb = mon_par ? 11 : 10;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL frame_unexpected: start bit seen with no queued byte");
        m_e = 8'h00;
      end else m_e = sb.pop_front();
      m_bits = mon_par ? {1'b1, ^m_e, m_e, 1'b0} : {1'b1, 1'b1, m_e, 1'b0};
      m_abort = 1'b0;
      m_bad = 0;
      for (int c = 0; c < m_nb * m_b && !m_abort; c++) begin
        if (c > 0) @(negedge clk_i);
        if (rst_i) m_abort = 1'b1;
        else if (tx_o !== m_bits[c / m_b]) begin
          if (m_bad == 0) begin
            m_badc = c;
            m_got = tx_o;
            m_exp = m_bits[c / m_b];
          end
          m_bad++;
        end
      end
      if (!m_abort) begin
        checks++;
        if (m_bad != 0) begin
          fails++;
          $display("FAIL frame byte=%02h: cycle %0d tx_o=%b expected %b (%0d bad cycles)",
                   m_e, m_badc, m_got, m_exp, m_bad);
        end
      end
      mon_busy = 1'b0;
    end
  end
  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog expired");
  end
  int cnt, bv, k;
  logic ie;
  logic [31:0] d;
  initial begin
    #2 rst_i = 1'b1;
    #1;
    chk("rst_tx_o", {31'd0, tx_o}, 32'd1);
    chk("rst_irq_o", {31'd0, irq_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_STAT, 32'h004, "rst_status");
    rd(A_BAUD, 32'h1B2, "rst_baud");
    wr(A_BAUD, 32'h0);
    rd(A_BAUD, 32'h1, "baud_zero_is_one");
    wr(A_BAUD, 32'hABCD1234);
    rd(A_BAUD, 32'h1234, "baud_low16");
    wr(A_CTRL, 32'hFFFFFFFE);
    rd(A_CTRL, 32'hFFFFFFFE & CTRL_MASK, "ctrl_mask");
    chk("irq_idle_empty", {31'd0, irq_o}, 32'd1);
    wr(A_CTRL, 32'h0);
    chk("irq_disabled", {31'd0, irq_o}, 32'd0);
    wr(A_STAT, 32'hFFFFFFF7);
    rd(A_STAT, 32'h004, "status_ro");
    wr(8'h10, 32'hFFFFFFFF);
    rd(A_CTRL, 32'h0, "unmapped_wr_ctrl");
    rd(A_BAUD, 32'h1234, "unmapped_wr_baud");
    rd(A_TX, 32'h0, "txdata_reads0");
    rd(8'hFC, 32'h0, "unmapped_reads0");
    wr(A_BAUD, 32'd4);
    mon_baud = 4;
    wr(A_CTRL, 32'h1);
    push_byte(32'h5A5A_00A5);
    addr_i = {24'd0, A_STAT};
    wait_start("a5_start");
    cnt = 0;
    while (data_o[0] === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk_i);
    end
    chk("a5_busy_len", cnt, 32'd40);
    drain("a5_drain", 200);
    wr(A_CTRL, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = $urandom;
      wr(A_TX, d);
      if (i < DEPTH) sb.push_back(d[7:0]);
    end
    rd(A_STAT, 32'h08A, "full_overflow");
    wr(A_STAT, 32'h8);
    rd(A_STAT, 32'h082, "overflow_w1c");
    wr(A_CTRL, 32'h1);
    wait_start("full_start");
    push_byte($urandom);
    repeat (10 * 4 - 4) @(negedge clk_i);
    push_byte($urandom);
    rd(A_STAT, 32'h083, "full_push_pop");
    drain("full_drain", 2000);
    wr(A_BAUD, 32'd2);
    mon_baud = 2;
    wr(A_CTRL, 32'h2);
    chk("irq_set", {31'd0, irq_o}, 32'd1);
    push_byte($urandom);
    push_byte($urandom);
    chk("irq_queued", {31'd0, irq_o}, 32'd0);
    wr(A_CTRL, 32'h3);
    wait_start("b2b_start");
    cnt = 0;
    while (irq_o !== 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk_i);
    end
    chk("b2b_irq_delay", cnt, 32'd40);
    drain("b2b_drain", 200);
    wr(A_CTRL, 32'h0);
    wr(A_BAUD, 32'd4);
    mon_baud = 4;
    wr(A_CTRL, 32'h1);
    push_byte(32'h0000_00F7);
    addr_i = {24'd0, A_STAT};
    wait_start("rst_frame_start");
    repeat (17) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("midframe_rst_tx", {31'd0, tx_o}, 32'd1);
    chk("midframe_rst_status", data_o, 32'h004);
    chk("midframe_rst_irq", {31'd0, irq_o}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    rd(A_BAUD, 32'h1B2, "post_rst_baud");
    cnt = 0;
    repeat (60) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) cnt++;
    end
    chk("post_rst_idle", cnt, 32'd0);
`ifdef UART_TX_PARITY_EN
    wr(A_BAUD, 32'd3);
    mon_baud = 3;
    mon_par = 1'b1;
    push_byte(32'h07);
    push_byte($urandom);
    wr(A_CTRL, 32'h5);
    drain("parity_drain", 500);
    wr(A_CTRL, 32'h0);
    mon_par = 1'b0;
`endif
    for (int r = 0; r < 8; r++) begin
      bv = $urandom_range(0, 5);
      k = $urandom_range(1, DEPTH);
      ie = 1'($urandom_range(0, 1));
      wr(A_CTRL, {30'd0, ie, 1'b0});
      d = $urandom;
      d[15:0] = 16'(bv);
      wr(A_BAUD, d);
      mon_baud = (bv == 0) ? 1 : bv;
      rd(A_BAUD, 32'(mon_baud), "rand_baud");
      for (int i = 0; i < k; i++) push_byte($urandom);
      rd(A_STAT, (32'(k) << 4) | ((k == DEPTH) ? 32'h2 : 32'h0), "rand_status_fill");
      wr(A_CTRL, {30'd0, ie, 1'b1});
      drain("rand_drain", 2000);
      rd(A_STAT, 32'h004, "rand_status_idle");
      chk("rand_irq", {31'd0, irq_o}, {31'd0, ie});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
